// File: rtl/ysyx_25010008_axi_sram.sv
// AXI4-Lite data-memory responder: one outstanding transaction, programmable response latency,
// SLVERR on out-of-range/misaligned access. Define SRAM_RAND_DELAY_EN to add LFSR jitter to the latency.
module ysyx_25010008_axi_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned FIXED_DELAY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr,
    input  logic [2:0]  arsize,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic [2:0]  awsize,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int unsigned IW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_RWAIT, S_RRESP, S_WDATA, S_WWAIT, S_BRESP
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [IW-1:0] idx_q;
    logic          err_q;
    logic [4:0]    cnt_q;
    logic [4:0]    dly;
    logic [31:0]   rdata_q;
    logic [1:0]    rresp_q, bresp_q;
    logic          rvalid_q, bvalid_q;
    logic          ar_hs, aw_hs, mem_we;

    function automatic logic addr_err(input logic [31:0] addr, input logic [2:0] size);
        logic [31:0] off;
        logic        oor;
        off = addr - ADDR_BASE;
        oor = (addr < ADDR_BASE) || (off >= SPAN);
        case (size)
            3'd0:    return oor;
            3'd1:    return oor || addr[0];
            3'd2:    return oor || (addr[1:0] != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - ADDR_BASE;
        return off[IW+1:2];
    endfunction

`ifdef SRAM_RAND_DELAY_EN
    // Fibonacci LFSR x^8+x^6+x^5+x^4; low bits add 0..7 cycles of jitter
    logic [7:0] lfsr_q;
    always_ff @(posedge clock) begin
        if (reset) lfsr_q <= 8'hA5;
        else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
    assign dly = 5'(FIXED_DELAY) + {2'b00, lfsr_q[2:0]};
`else
    assign dly = 5'(FIXED_DELAY);
`endif

    assign ar_hs = arvalid & arready;
    assign aw_hs = awvalid & awready;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a read request always beats a concurrent write request
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ar_hs)      state_d = S_RWAIT;
                else if (aw_hs) state_d = S_WDATA;
            end
            S_RWAIT: if (cnt_q == 5'd0) state_d = S_RRESP;
            S_RRESP: if (rready)        state_d = S_IDLE;
            S_WDATA: if (wvalid)        state_d = S_WWAIT;
            S_WWAIT: if (cnt_q == 5'd0) state_d = S_BRESP;
            S_BRESP: if (bready)        state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    // Output logic: ready signals are pure functions of state
    always_comb begin
        arready = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        if (!reset) begin
            arready = (state_q == S_IDLE);
            awready = (state_q == S_IDLE) & ~arvalid;
            wready  = (state_q == S_WDATA);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q    <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rresp_q  <= OKAY;
            bresp_q  <= OKAY;
            rvalid_q <= 1'b0;
            bvalid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ar_hs) begin
                        idx_q <= word_idx(araddr);
                        err_q <= addr_err(araddr, arsize);
                        cnt_q <= dly;
                    end else if (aw_hs) begin
                        idx_q <= word_idx(awaddr);
                        err_q <= addr_err(awaddr, awsize);
                    end
                end
                S_RWAIT: begin
                    if (cnt_q == 5'd0) begin
                        rdata_q  <= err_q ? 32'h0 : mem[idx_q];
                        rresp_q  <= err_q ? SLVERR : OKAY;
                        rvalid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                S_RRESP: if (rready) rvalid_q <= 1'b0;
                S_WDATA: if (wvalid) cnt_q <= dly;
                S_WWAIT: begin
                    if (cnt_q == 5'd0) begin
                        bresp_q  <= err_q ? SLVERR : OKAY;
                        bvalid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                S_BRESP: if (bready) bvalid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Data commits at the W handshake edge; faulted or reset-aborted writes leave memory untouched
    assign mem_we = (state_q == S_WDATA) & wvalid & ~err_q & ~reset;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[idx_q][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata  = rdata_q;
    assign rresp  = rresp_q;
    assign rvalid = rvalid_q;
    assign bresp  = bresp_q;
    assign bvalid = bvalid_q;

endmodule

// File: doc/ysyx_25010008_axi_sram.md
# ysyx_25010008_axi_sram

AXI4-Lite responder that models the on-chip data memory behind the LSU's read/write channels. Accepts one outstanding transaction at a time, services reads and strobe-masked writes against an internal word array after a programmable latency, and reports SLVERR for out-of-range or misaligned accesses. It sits at the slave end of the LSU (or the crossbar port feeding it) and exercises the master's full multi-cycle handshake.

## Interface

Parameters:
- `ADDR_BASE`, 32'h8000_0000, byte address of word 0
- `DEPTH_WORDS`, 4096, array size in 32-bit words (power of two)
- `FIXED_DELAY`, 1, extra cycles between address/data acceptance and response (0..15)

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `araddr`  in  32  read byte address
- `arsize`  in  3  0=byte, 1=half, 2=word
- `arvalid`  in  1  read address valid
- `arready`  out  1  read address accept
- `rdata`  out  32  full aligned word, unshifted
- `rresp`  out  2  00 OKAY, 10 SLVERR
- `rvalid`  out  1  read response valid
- `rready`  in  1  master accepts read response
- `awaddr`  in  32  write byte address
- `awsize`  in  3  as `arsize`
- `awvalid`  in  1  write address valid
- `awready`  out  1  write address accept
- `wdata`  in  32  lane-aligned write data
- `wstrb`  in  4  byte enables
- `wvalid`  in  1  write data valid
- `wready`  out  1  write data accept
- `bresp`  out  2  00 OKAY, 10 SLVERR
- `bvalid`  out  1  write response valid
- `bready`  in  1  master accepts write response

## Operation

- States: IDLE, RWAIT, RRESP, WDATA, WWAIT, BRESP.
- `arready` = (state==IDLE) & ~reset; `awready` = (state==IDLE) & ~arvalid & ~reset; `wready` = (state==WDATA). All combinational from state.
- IDLE: read handshake latches address/size, computes error, loads delay counter -> RWAIT. Else write address handshake latches address/size/error -> WDATA. Simultaneous arvalid+awvalid: read wins, write held off.
- RWAIT: counter decrements; at 0 register `rdata`=mem[index] (0 if error), `rresp`, set `rvalid` -> RRESP.
- RRESP: hold `rvalid`/`rdata`/`rresp` stable until `rready`; on handshake clear `rvalid` -> IDLE.
- WDATA: on `wvalid`, if no error write bytes where `wstrb[i]`=1; load counter -> WWAIT.
- WWAIT: counter reaches 0 -> set `bvalid`, `bresp` -> BRESP. BRESP: hold until `bready` -> IDLE.
- Decode: in range iff ADDR_BASE <= addr < ADDR_BASE+4*DEPTH_WORDS; index = (addr-ADDR_BASE)[log2(DEPTH)+1:2]. Error = out of range, or size 1 with addr[0]=1, or size 2 with addr[1:0]!=0, or size >2. Erroneous writes never modify memory.
- `wstrb` is trusted as supplied; no cross-check against `awsize`.

## Timing

- Reset values: `rvalid`=0, `bvalid`=0, `rdata`=0, `rresp`=0, `bresp`=0, state=IDLE; ready outputs low while `reset` high, `arready`/`awready` high in first cycle after release. Memory array is not reset.
- Reset mid-transaction: aborts immediately, no partial write after the reset edge, responses dropped.
- Read: ar handshake at edge T -> `rvalid` high in cycle T+1+D (D = delay). D=0 gives 1-cycle latency.
- Write: w handshake at edge W commits data at that edge -> `bvalid` high in cycle W+1+D.
- Back-to-back: next ar/aw accepted in the cycle after the r/b handshake (one idle cycle minimum).
- A read issued in the cycle after a write's b handshake returns the new data.

## Configuration

- `SRAM_RAND_DELAY_EN` defined: 8-bit LFSR (taps 8,6,5,4), seed 8'hA5 at reset, steps every cycle; D = FIXED_DELAY + lfsr[2:0] sampled at each ar or w handshake. Stresses master stall handling.
- Undefined: D = FIXED_DELAY exactly; no LFSR logic.

## Test plan

- FIXED_DELAY=0, word write 32'hDEADBEEF to 8000_0010 strb 1111, read back -> bresp=00, rvalid at T+1, rdata=DEADBEEF, rresp=00.
- Byte write wdata=32'h0000_AB00 strb 0010 to 8000_0011 over word 11223344 -> read 8000_0010 returns 1122AB44.
- Read 0x9000_0000 and half-read 8000_0001 -> rresp=10, rdata=0; write to 0x7FFF_FFFC -> bresp=10, memory unchanged.
- arvalid and awvalid raised together -> read completes first, awready held low until read's r handshake done, then write accepted.
- FIXED_DELAY=3, rready held low 5 cycles after rvalid -> rvalid at T+4, rdata/rresp stable until rready, then state IDLE next cycle.
- Reset asserted in WWAIT -> bvalid stays 0, after release arready=awready=1, no spurious response.
